// File: rtl/uart_msg_sequencer.sv
// uart_msg_sequencer: samples one-hot colour detections tagged with a site
// index, drops repeats, queues accepted events and serialises each one as a
// fixed ASCII status message over a valid/done UART handshake.
// Build macro UMS_CHECKSUM_EN: appends a 12th byte, the XOR of bytes 0-10.
module uart_msg_sequencer #(
  parameter int unsigned       N_CH        = 3,
  parameter logic [8*N_CH-1:0] COLOR_CHARS = "NWP",
  parameter int unsigned       SITE_W      = 2,
  parameter int unsigned       FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              detect_en,
  input  logic [N_CH-1:0]   color_in,
  input  logic [SITE_W-1:0] site_idx,
  input  logic              o_tx_done,
  output logic              tx_data_valid,
  output logic [7:0]        tx_byte,
  output logic [N_CH-1:0]   led,
  output logic              busy,
  output logic              fifo_full,
  output logic              overflow,
  output logic [7:0]        msg_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = SITE_W + 3;
`ifdef UMS_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd11;
`else
  localparam logic [3:0] LAST_IDX = 4'd10;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT} state_t;

  state_t            r_state;
  logic              r_den_q;
  logic [N_CH-1:0]   r_col_q;
  logic [SITE_W-1:0] r_site_q;
  logic              r_last_vld;
  logic [2:0]        r_last_ch;
  logic [SITE_W-1:0] r_last_site;
  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [EW-1:0]     r_cur;
  logic [7:0]        r_digit;
  logic [7:0]        r_letter;
  logic [3:0]        r_idx;

  logic [2:0]        w_ch;
  logic              w_zero;
  logic              w_push;
  logic              w_pop;
  logic              w_do_push;
  logic [7:0]        w_digit;
  logic [7:0]        w_letter;

  // Message body: "SI-SIM" <digit> "-" <letter> "-#"
  function automatic logic [7:0] base_byte(input logic [3:0] idx,
                                           input logic [7:0] dig,
                                           input logic [7:0] ltr);
    logic [7:0] b;
    case (idx)
      4'd0, 4'd3: b = "S";
      4'd1, 4'd4: b = "I";
      4'd5:       b = "M";
      4'd6:       b = dig;
      4'd8:       b = ltr;
      4'd10:      b = "#";
      default:    b = "-";
    endcase
    return b;
  endfunction

  function automatic logic [7:0] msg_byte(input logic [3:0] idx,
                                          input logic [7:0] dig,
                                          input logic [7:0] ltr);
    logic [7:0] b;
`ifdef UMS_CHECKSUM_EN
    if (idx == 4'd11) begin
      b = '0;
      for (int unsigned i = 0; i < 11; i++) b ^= base_byte(4'(i), dig, ltr);
    end else begin
      b = base_byte(idx, dig, ltr);
    end
`else
    b = base_byte(idx, dig, ltr);
`endif
    return b;
  endfunction

  assign w_zero    = (r_col_q == '0);
  assign fifo_full = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  assign w_push    = r_den_q && $onehot(r_col_q) &&
                     !(r_last_vld && (w_ch == r_last_ch) && (r_site_q == r_last_site));
  // A full queue still accepts a push when the head leaves on the same edge.
  assign w_do_push = w_push && (!fifo_full || w_pop);
  assign w_digit   = 8'h31 + 8'(r_cur[EW-1:3]);
  assign busy      = (r_state != S_IDLE);

  // Channel index of the sampled one-hot detection
  always_comb begin
    w_ch = '0;
    for (int unsigned k = 0; k < N_CH; k++)
      if (r_col_q[k]) w_ch = 3'(k);
  end

  // Message letter for the channel of the event being loaded
  always_comb begin
    w_letter = '0;
    for (int unsigned k = 0; k < N_CH; k++)
      if (r_cur[2:0] == 3'(k)) w_letter = COLOR_CHARS[8*k +: 8];
  end

  // Input sampling register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_den_q  <= 1'b0;
      r_col_q  <= '0;
      r_site_q <= '0;
    end else begin
      r_den_q  <= detect_en;
      r_col_q  <= color_in;
      r_site_q <= site_idx;
    end
  end

  // De-duplication memory, LED and overflow pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      led         <= '0;
      r_last_vld  <= 1'b0;
      r_last_ch   <= '0;
      r_last_site <= '0;
      overflow    <= 1'b0;
    end else begin
      overflow <= w_push && fifo_full && !w_pop;
      if (r_den_q && w_zero) begin
        led        <= '0;
        r_last_vld <= 1'b0;
      end else if (w_push) begin
        led         <= r_col_q;
        r_last_vld  <= 1'b1;
        r_last_ch   <= w_ch;
        r_last_site <= r_site_q;
      end
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // Queue storage
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= {r_site_q, w_ch};
  end

  // Message sequencer with registered UART request outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cur         <= '0;
      r_digit       <= '0;
      r_letter      <= '0;
      r_idx         <= '0;
      tx_data_valid <= 1'b0;
      tx_byte       <= '0;
      msg_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cur   <= r_mem[r_rd_ptr];
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_digit       <= w_digit;
          r_letter      <= w_letter;
          r_idx         <= '0;
          tx_byte       <= msg_byte(4'd0, w_digit, w_letter);
          tx_data_valid <= 1'b1;
          r_state       <= S_SEND;
        end
        S_SEND: begin
          if (!o_tx_done) begin
            tx_data_valid <= 1'b0;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (o_tx_done) begin
            if (r_idx == LAST_IDX) begin
              msg_count <= msg_count + 8'd1;
              r_state   <= S_IDLE;
            end else begin
              r_idx         <= r_idx + 4'd1;
              tx_byte       <= msg_byte(r_idx + 4'd1, r_digit, r_letter);
              tx_data_valid <= 1'b1;
              r_state       <= S_SEND;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
